// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM with memory wait timeout and retire counter
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode_i,
  input  logic        br_taken_i,
  input  logic        imem_rsp_valid_i,
  input  logic        dmem_rsp_valid_i,
  output logic        imem_req_o,
  output logic        insn_we_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        rf_we_o,
  output logic        pc_we_o,
  output logic        pc_sel_o,
  output logic [2:0]  state_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] instret_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Counter holds 0..TIMEOUT-1; the cycle it would reach TIMEOUT is the timeout cycle.
  localparam int            CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [6:0]    op_class;
  logic [CW-1:0] wait_cnt;
  logic          fault_q;
  logic [31:0]   instret_cnt;
  logic          wait_hit;
  logic          op_legal;

  assign wait_hit = (wait_cnt == WAIT_LAST);

  // Opcode whitelist checked while the instruction register is being decoded
  always_comb begin
    op_legal = 1'b0;
    case (opcode_i)
      OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BRANCH, OP_LOAD, OP_STORE, OP_SYSTEM: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // Per-state control outputs; reset suppresses every request and write pulse
  always_comb begin
    imem_req_o = 1'b0;
    insn_we_o  = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          imem_req_o = 1'b1;
          insn_we_o  = imem_rsp_valid_i;
        end
        S_EXECUTE: begin
          if (op_class == OP_BRANCH) begin
            pc_we_o  = 1'b1;
            pc_sel_o = br_taken_i;
          end
        end
        S_MEM: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = (op_class == OP_STORE);
          pc_we_o    = dmem_rsp_valid_i && (op_class == OP_STORE);
        end
        S_WB: begin
          rf_we_o  = 1'b1;
          pc_we_o  = 1'b1;
          pc_sel_o = (op_class == OP_JAL) || (op_class == OP_JALR);
        end
        default: ;
      endcase
    end
  end

  assign state_o   = state;
  assign halted_o  = (state_o >= 3'd5);
  assign fault_o   = fault_q || (state_o > 3'd5);
  assign instret_o = instret_cnt;

  // State sequencing, wait timeout, halt cause and retire counting
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      op_class    <= 7'd0;
      wait_cnt    <= '0;
      fault_q     <= 1'b0;
      instret_cnt <= 32'd0;
    end else begin
      instret_cnt <= instret_cnt + 32'(pc_we_o);
      case (state)
        S_FETCH: begin
          if (imem_rsp_valid_i) begin
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (wait_hit) begin
            wait_cnt <= '0;
            fault_q  <= 1'b1;
            state    <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          op_class <= opcode_i;
          if (!op_legal) begin
            fault_q <= 1'b1;
            state   <= S_HALT;
          end else if (opcode_i == OP_SYSTEM) begin
            state <= S_HALT;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (op_class == OP_LOAD || op_class == OP_STORE) state <= S_MEM;
          else if (op_class == OP_BRANCH)                  state <= S_FETCH;
          else                                             state <= S_WB;
        end
        S_MEM: begin
          if (dmem_rsp_valid_i) begin
            wait_cnt <= '0;
            state    <= (op_class == OP_LOAD) ? S_WB : S_FETCH;
          end else if (wait_hit) begin
            wait_cnt <= '0;
            fault_q  <= 1'b1;
            state    <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_WB:    state <= S_FETCH;
        default: state <= state;
      endcase
    end
  end

endmodule
